// File: rtl/matrix_cps_pkg.sv
// Shared types and width constants for the matrix coprocessor front end.
package matrix_cps_pkg;

  localparam int MATRIX_INSTR_W = 32;
  localparam int MATRIX_ID_W    = 4;
  localparam int MATRIX_RS_W    = 32;

  // One buffered instruction. vld marks an occupied slot, cmt means the
  // core has resolved it (commit or kill), and kil means it must be dropped.
  typedef struct packed {
    logic [MATRIX_INSTR_W-1:0] instr;
    logic [MATRIX_ID_W-1:0]    id;
    logic [MATRIX_RS_W-1:0]    rs1;
    logic [MATRIX_RS_W-1:0]    rs2;
    logic                      vld;
    logic                      cmt;
    logic                      kil;
  } commit_buf_entry_t;

endpackage

// File: rtl/matrix_commit_match.sv
// DEPTH-way commit ID comparator. It returns a one-hot match vector over the
// buffered entries plus a flag for the instruction being pushed this cycle.
module matrix_commit_match
  import matrix_cps_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = MATRIX_ID_W
) (
  input  logic                       commit_valid_i,
  input  logic [ID_W-1:0]            commit_id_i,
  input  logic [DEPTH-1:0]           vld_i,
  input  logic [DEPTH-1:0]           cmt_i,
  input  logic [DEPTH-1:0][ID_W-1:0] ids_i,
  input  logic                       push_i,
  input  logic [ID_W-1:0]            push_id_i,
  output logic [DEPTH-1:0]           match_o,
  output logic                       push_match_o
);

  // Only live, still-unresolved entries can match, so a repeated commit or a
  // late kill of an already-committed entry has no effect.
  always_comb begin
    match_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_o[i] = commit_valid_i && vld_i[i] && !cmt_i[i] && (ids_i[i] == commit_id_i);
    end
    push_match_o = commit_valid_i && push_i && (push_id_i == commit_id_i);
  end

endmodule

// File: rtl/matrix_commit_buffer.sv
// Commit-gated in-order instruction buffer between the X issue interface and
// the matrix coprocessor dispatch. Entries wait for their commit, leave in
// program order, and killed entries are dropped at the head without output.
module matrix_commit_buffer
  import matrix_cps_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = MATRIX_INSTR_W,
  parameter int ID_W    = MATRIX_ID_W,
  parameter int RS_W    = MATRIX_RS_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [INSTR_W-1:0]         in_instr_i,
  input  logic [ID_W-1:0]            in_id_i,
  input  logic [RS_W-1:0]            in_rs1_i,
  input  logic [RS_W-1:0]            in_rs2_i,
  input  logic                       commit_valid_i,
  input  logic [ID_W-1:0]            commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [INSTR_W-1:0]         out_instr_o,
  output logic [ID_W-1:0]            out_id_o,
  output logic [RS_W-1:0]            out_rs1_o,
  output logic [RS_W-1:0]            out_rs2_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       empty_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  commit_buf_entry_t entries_q [DEPTH];
  commit_buf_entry_t entries_d [DEPTH];
  logic [PW:0]       wr_ptr_q, wr_ptr_d;
  logic [PW:0]       rd_ptr_q, rd_ptr_d;

  logic [PW-1:0]           wr_idx, rd_idx;
  logic                    full, empty;
  logic                    push, pop;
  logic                    head_release, head_drop;
  commit_buf_entry_t       head;
  logic [DEPTH-1:0]        vld_vec, cmt_vec;
  logic [DEPTH-1:0][ID_W-1:0] id_vec;
  logic [DEPTH-1:0]        match_vec;
  logic                    push_match;

  assign wr_idx = wr_ptr_q[PW-1:0];
  assign rd_idx = rd_ptr_q[PW-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_idx == rd_idx);
  assign head   = entries_q[rd_idx];

  // Head status: a committed live head is offered downstream, a killed head
  // is silently retired, anything else stalls every younger entry.
  always_comb begin
    head_release = head.vld && head.cmt && !head.kil;
    head_drop    = head.vld && head.kil;
    pop          = (head_release && out_ready_i) || head_drop;
    push         = in_valid_i && !full;
  end

  // Flatten entry flags and IDs for the comparator.
  always_comb begin
    vld_vec = '0;
    cmt_vec = '0;
    id_vec  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      vld_vec[i] = entries_q[i].vld;
      cmt_vec[i] = entries_q[i].cmt;
      id_vec[i]  = entries_q[i].id;
    end
  end

  matrix_commit_match #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_match (
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .vld_i          (vld_vec),
    .cmt_i          (cmt_vec),
    .ids_i          (id_vec),
    .push_i         (push),
    .push_id_i      (in_id_i),
    .match_o        (match_vec),
    .push_match_o   (push_match)
  );

  // Next-state for storage and pointers. The write slot is never live while
  // not full and the popped head is never a match target, so commit, pop and
  // push touch disjoint state and may all happen together.
  always_comb begin
    entries_d = entries_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;

    for (int i = 0; i < DEPTH; i++) begin
      if (match_vec[i]) begin
        entries_d[i].cmt = 1'b1;
        entries_d[i].kil = commit_kill_i;
      end
    end

    if (pop) begin
      entries_d[rd_idx].vld = 1'b0;
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    if (push) begin
      entries_d[wr_idx].instr = in_instr_i;
      entries_d[wr_idx].id    = in_id_i;
      entries_d[wr_idx].rs1   = in_rs1_i;
      entries_d[wr_idx].rs2   = in_rs2_i;
      entries_d[wr_idx].vld   = 1'b1;
      entries_d[wr_idx].cmt   = push_match;
      entries_d[wr_idx].kil   = push_match && commit_kill_i;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
  end

  // State registers; reset discards every entry including committed ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      entries_q <= entries_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
    end
  end

  // Outputs come straight from registered state, so in_ready_o never sees
  // out_ready_i combinationally.
  always_comb begin
    in_ready_o  = !full;
    out_valid_o = head_release;
    out_instr_o = head.instr;
    out_id_o    = head.id;
    out_rs1_o   = head.rs1;
    out_rs2_o   = head.rs2;
    count_o     = CNT_W'(wr_ptr_q - rd_ptr_q);
    empty_o     = empty;
  end

endmodule

// File: tb/tb_matrix_commit_buffer.sv
// Directed self-checking bench for matrix_commit_buffer (DEPTH=4).
module tb_matrix_commit_buffer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_instr_i;
  logic [3:0]  in_id_i;
  logic [31:0] in_rs1_i;
  logic [31:0] in_rs2_i;
  logic        commit_valid_i;
  logic [3:0]  commit_id_i;
  logic        commit_kill_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_instr_o;
  logic [3:0]  out_id_o;
  logic [31:0] out_rs1_o;
  logic [31:0] out_rs2_o;
  logic [2:0]  count_o;
  logic        empty_o;

  int testsRun    = 0;
  int testsFailed = 0;

  matrix_commit_buffer #(
    .DEPTH   (4),
    .INSTR_W (32),
    .ID_W    (4),
    .RS_W    (32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_instr_i     (in_instr_i),
    .in_id_i        (in_id_i),
    .in_rs1_i       (in_rs1_i),
    .in_rs2_i       (in_rs2_i),
    .commit_valid_i (commit_valid_i),
    .commit_id_i    (commit_id_i),
    .commit_kill_i  (commit_kill_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_instr_o    (out_instr_o),
    .out_id_o       (out_id_o),
    .out_rs1_o      (out_rs1_o),
    .out_rs2_o      (out_rs2_o),
    .count_o        (count_o),
    .empty_o        (empty_o)
  );

  // Free-running 10-unit clock.
  always #5 clk_i = ~clk_i;

  // Payload fields are tagged with the ID so a wrong slot shows up at once.
  function automatic logic [31:0] instrOf(input logic [3:0] id);
    return 32'h1000_0000 | 32'(id);
  endfunction

  function automatic logic [31:0] rs2Of(input logic [3:0] id);
    return 32'h3000_0000 | 32'(id);
  endfunction

  // Drive one cycle of inputs at the falling edge, let the rising edge take
  // them, and return at the next falling edge for sampling.
  task automatic applyStimulus(input logic pushV, input logic [3:0] pushId,
                               input logic commitV, input logic [3:0] commitId,
                               input logic kill, input logic outReady);
    in_valid_i     = pushV;
    in_id_i        = pushId;
    in_instr_i     = instrOf(pushId);
    in_rs1_i       = 32'h2000_0000 | 32'(pushId);
    in_rs2_i       = rs2Of(pushId);
    commit_valid_i = commitV;
    commit_id_i    = commitId;
    commit_kill_i  = kill;
    out_ready_i    = outReady;
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_i          = 1'b1;
    in_valid_i     = 1'b0;
    in_id_i        = '0;
    in_instr_i     = '0;
    in_rs1_i       = '0;
    in_rs2_i       = '0;
    commit_valid_i = 1'b0;
    commit_id_i    = '0;
    commit_kill_i  = 1'b0;
    out_ready_i    = 1'b0;
    @(negedge clk_i);
    @(negedge clk_i);

    checkOutput("rst_in_ready",  32'(in_ready_o), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid_o), 32'd0);
    checkOutput("rst_count",     32'(count_o), 32'd0);
    checkOutput("rst_empty",     32'(empty_o), 32'd1);
    checkOutput("rst_instr",     out_instr_o, 32'd0);
    rst_i = 1'b0;

    // In-order release behind an uncommitted head.
    applyStimulus(1, 4'd1, 0, 4'd0, 0, 1);
    applyStimulus(1, 4'd2, 0, 4'd0, 0, 1);
    applyStimulus(1, 4'd3, 0, 4'd0, 0, 1);
    checkOutput("fill3_count", 32'(count_o), 32'd3);
    checkOutput("fill3_valid", 32'(out_valid_o), 32'd0);
    checkOutput("fill3_empty", 32'(empty_o), 32'd0);
    applyStimulus(0, 4'd0, 1, 4'd2, 0, 1);
    checkOutput("younger_cmt_blocked", 32'(out_valid_o), 32'd0);
    applyStimulus(0, 4'd0, 1, 4'd1, 0, 1);
    checkOutput("head1_valid", 32'(out_valid_o), 32'd1);
    checkOutput("head1_id",    32'(out_id_o), 32'd1);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("head2_valid", 32'(out_valid_o), 32'd1);
    checkOutput("head2_id",    32'(out_id_o), 32'd2);
    checkOutput("head2_count", 32'(count_o), 32'd2);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("id3_held_valid", 32'(out_valid_o), 32'd0);
    checkOutput("id3_held_count", 32'(count_o), 32'd1);
    applyStimulus(0, 4'd0, 1, 4'd3, 0, 1);
    checkOutput("id3_valid", 32'(out_valid_o), 32'd1);
    checkOutput("id3_id",    32'(out_id_o), 32'd3);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("drain1_empty", 32'(empty_o), 32'd1);

    // Push with same-cycle commit on an empty buffer.
    applyStimulus(1, 4'd5, 1, 4'd5, 0, 0);
    checkOutput("bypass_valid", 32'(out_valid_o), 32'd1);
    checkOutput("bypass_id",    32'(out_id_o), 32'd5);
    checkOutput("bypass_instr", out_instr_o, 32'h1000_0005);

    // Sustained push+pop: count holds while ID5 leaves and ID6 arrives.
    applyStimulus(1, 4'd6, 1, 4'd6, 0, 1);
    checkOutput("stream_count", 32'(count_o), 32'd1);
    checkOutput("stream_id",    32'(out_id_o), 32'd6);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("drain2_count", 32'(count_o), 32'd0);

    // Kill drain of the head, then a committed follower.
    applyStimulus(1, 4'd7, 0, 4'd0, 0, 0);
    applyStimulus(1, 4'd8, 0, 4'd0, 0, 0);
    checkOutput("kill_pre_count", 32'(count_o), 32'd2);
    applyStimulus(0, 4'd0, 1, 4'd7, 1, 0);
    checkOutput("kill_no_valid", 32'(out_valid_o), 32'd0);
    checkOutput("kill_count2",   32'(count_o), 32'd2);
    applyStimulus(0, 4'd0, 1, 4'd8, 0, 1);
    checkOutput("kill_count1", 32'(count_o), 32'd1);
    checkOutput("kill_next_valid", 32'(out_valid_o), 32'd1);
    checkOutput("kill_next_id",    32'(out_id_o), 32'd8);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("kill_count0", 32'(count_o), 32'd0);

    // Fresh pointers, then fill to DEPTH and wrap the write pointer.
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(1, 4'd10, 0, 4'd0, 0, 0);
    applyStimulus(1, 4'd11, 0, 4'd0, 0, 0);
    applyStimulus(1, 4'd12, 0, 4'd0, 0, 0);
    applyStimulus(1, 4'd13, 0, 4'd0, 0, 0);
    checkOutput("full_count", 32'(count_o), 32'd4);
    checkOutput("full_ready", 32'(in_ready_o), 32'd0);
    applyStimulus(1, 4'd9, 1, 4'd10, 0, 0);
    checkOutput("full_push_ignored", 32'(count_o), 32'd4);
    checkOutput("hold0_valid", 32'(out_valid_o), 32'd1);
    checkOutput("hold0_id",    32'(out_id_o), 32'd10);

    // Backpressure: payload stable; unmatched and late-kill commits ignored.
    applyStimulus(0, 4'd0, 1, 4'd15, 0, 0);
    checkOutput("hold1_id",    32'(out_id_o), 32'd10);
    checkOutput("hold1_count", 32'(count_o), 32'd4);
    applyStimulus(0, 4'd0, 1, 4'd10, 1, 0);
    checkOutput("hold2_valid", 32'(out_valid_o), 32'd1);
    checkOutput("hold2_rs2",   out_rs2_o, 32'h3000_000A);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 0);
    checkOutput("hold3_instr", out_instr_o, 32'h1000_000A);
    checkOutput("hold3_count", 32'(count_o), 32'd4);

    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("after_pop_ready", 32'(in_ready_o), 32'd1);
    checkOutput("after_pop_count", 32'(count_o), 32'd3);
    checkOutput("after_pop_valid", 32'(out_valid_o), 32'd0);
    applyStimulus(1, 4'd14, 1, 4'd11, 0, 1);
    checkOutput("wrap_count", 32'(count_o), 32'd4);
    checkOutput("wrap_ready", 32'(in_ready_o), 32'd0);
    checkOutput("wrap_head",  32'(out_id_o), 32'd11);
    applyStimulus(0, 4'd0, 1, 4'd12, 0, 1);
    checkOutput("wrap_id12", 32'(out_id_o), 32'd12);
    applyStimulus(0, 4'd0, 1, 4'd13, 0, 1);
    checkOutput("wrap_id13", 32'(out_id_o), 32'd13);
    applyStimulus(0, 4'd0, 1, 4'd14, 0, 1);
    checkOutput("wrap_id14",    32'(out_id_o), 32'd14);
    checkOutput("wrap_rs2_14",  out_rs2_o, 32'h3000_000E);
    checkOutput("wrap_count14", 32'(count_o), 32'd1);
    applyStimulus(0, 4'd0, 0, 4'd0, 0, 1);
    checkOutput("wrap_empty", 32'(empty_o), 32'd1);

    // Reset with three entries buffered, one committed.
    applyStimulus(1, 4'd1, 0, 4'd0, 0, 0);
    applyStimulus(1, 4'd2, 0, 4'd0, 0, 0);
    applyStimulus(1, 4'd3, 1, 4'd1, 0, 0);
    checkOutput("prerst_valid", 32'(out_valid_o), 32'd1);
    checkOutput("prerst_count", 32'(count_o), 32'd3);
    in_valid_i     = 1'b0;
    commit_valid_i = 1'b0;
    rst_i          = 1'b1;
    #1;
    checkOutput("midrst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("midrst_count", 32'(count_o), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready_o), 32'd1);
    checkOutput("midrst_id",    32'(out_id_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    applyStimulus(0, 4'd0, 1, 4'd2, 0, 1);
    checkOutput("postrst_valid", 32'(out_valid_o), 32'd0);
    checkOutput("postrst_empty", 32'(empty_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/matrix_commit_buffer.md
# matrix_commit_buffer

Commit-gated, in-order instruction buffer feeding the matrix coprocessor's decode/dispatch stage from the eXtension issue interface. Accepted instructions are held with their ID and source operands until the core's commit transaction for that ID arrives. Committed entries are released to the coprocessor in program order. Killed entries are silently discarded. This is the stage sized by `INPUT_BUFFER_DEPTH` in the coprocessor wrapper.

## Interface
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `INSTR_W`, 32: instruction word width.
- `ID_W`, 4: X-interface instruction ID width.
- `RS_W`, 32: width of each source operand.
- `clk_i` in 1: clock; all state on rising edge.
- `rst_i` in 1: reset, asynchronous, active-high; clears all entries and pointers.
- `in_valid_i` in 1: issue-accepted instruction present.
- `in_ready_o` out 1: buffer can take an entry this cycle.
- `in_instr_i` in INSTR_W: instruction word.
- `in_id_i` in ID_W: instruction ID.
- `in_rs1_i`, `in_rs2_i` in RS_W: source operands.
- `commit_valid_i` in 1: commit transaction strobe.
- `commit_id_i` in ID_W: ID being committed or killed.
- `commit_kill_i` in 1: 1 = kill, 0 = commit.
- `out_valid_o` out 1: committed head entry available.
- `out_ready_i` in 1: downstream accepts.
- `out_instr_o` out INSTR_W, `out_id_o` out ID_W, `out_rs1_o`/`out_rs2_o` out RS_W: head payload.
- `count_o` out $clog2(DEPTH+1): occupied entries.
- `empty_o` out 1: count_o == 0.

## Operation
- Storage is a circular buffer with read/write pointers of $clog2(DEPTH) bits plus a wrap bit. Full/empty come from pointer and wrap comparison, and the pointers wrap modulo DEPTH.
- Per-entry flags: `vld`, `cmt`, `kil`.
- Push: `in_valid_i && in_ready_o` writes payload at the write pointer, sets `vld`, and clears `cmt` and `kil`.
- `in_ready_o` = !full. It does not depend on a same-cycle pop, so there is no combinational path from `out_ready_i` to `in_ready_o`.
- Commit lookup:
  - `commit_valid_i` compares `commit_id_i` against all `vld` entries and sets `cmt` on the match, or `cmt` and `kil` if `commit_kill_i`.
  - It also compares against `in_id_i` of a same-cycle push; on a match the new entry is written with the flags already set.
- Commit edge cases:
  - An unmatched commit is ignored and leaves state unchanged.
  - A second commit to an already-committed entry is ignored.
  - IDs are unique among buffered entries. Uniqueness is a precondition and is guaranteed by the issue logic.
- Head release:
  - `out_valid_o` = head `vld && cmt && !kil`.
  - `out_valid_o && out_ready_i` pops the head.
- Kill drain: if the head has `vld && kil`, the head is popped without asserting `out_valid_o`. At most one drop per cycle.
- Blocking: an uncommitted head blocks all younger entries, including committed ones. Release is strictly in order.
- Simultaneous events: push, pop/drop and commit may all occur in one cycle.
  - `count_o` updates by +1 / 0 / −1 accordingly.
  - When full, push and pop never occur together because `in_ready_o`=0.
- Reset mid-operation drops all entries, including committed-but-unreleased ones. The upstream core is expected to reset at the same time.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `count_o`=0, `empty_o`=1. Payload outputs are 0 because storage is reset.
- Latency:
  - Push and commit in the same cycle N on an empty buffer gives `out_valid_o` at N+1.
  - Commit arriving at N for an entry already at the head gives `out_valid_o` at N+1.
- Kill of the head at N: dropped at the N+1 edge; the next entry is visible at N+2 at the earliest.
- Handshake: while `out_valid_o && !out_ready_i`, the payload and `out_valid_o` hold stable. A later kill cannot target the head because it is already committed.
- Throughput: one push and one pop per cycle sustained.
- `in_ready_o` reflects state after the previous edge: full at N means not ready for the whole of cycle N.

## Structure
- Shared package `matrix_cps_pkg`: the entry struct `commit_buf_entry_t` (instr, id, rs1, rs2, vld, cmt, kil). Its widths come from package constants `MATRIX_INSTR_W`, `MATRIX_ID_W` and `MATRIX_RS_W`, which serve as the parameter defaults.
- One natural sub-module: `matrix_commit_match`. It is the combinational DEPTH-way ID comparator that returns a one-hot match vector for `commit_id_i` plus a same-cycle push-match flag.
- Pointers, flags and head logic stay in the top module.

## Test plan
- Push IDs 1,2,3 with no commits → `count_o`=3, `out_valid_o`=0; commit 2 → still 0; commit 1 → ID1 then ID2 out on consecutive cycles with `out_ready_i`=1, ID3 held.
- Push ID5 with a same-cycle commit of 5 on an empty buffer → `out_valid_o`=1 next cycle, `out_id_o`=5.
- Push 7,8; kill 7, commit 8 → 7 dropped without `out_valid_o`, 8 output; `count_o` goes 2→1→0.
- Fill DEPTH=4 → `in_ready_o`=0; commit the head and pop → `in_ready_o`=1 the next cycle; the subsequent push wraps the write pointer to slot 0.
- Hold `out_ready_i`=0 for 3 cycles with a committed head → payload stable; an unmatched commit of ID 15 → no state change.
- Assert `rst_i` with 3 entries buffered, one committed → immediately `out_valid_o`=0, `count_o`=0, `in_ready_o`=1.
